// File: rtl/vehicle_link_pkg.sv
// Shared constants and types for the host link: status/command widths,
// the status transmitter state encoding and the ping reply words.
package vehicle_link_pkg;
  localparam int STATUS_W = 24;
  localparam int CMD_W    = 8;

  localparam logic [STATUS_W-1:0] PING_A = 24'hAAA;
  localparam logic [STATUS_W-1:0] PING_5 = 24'h555;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;
endpackage

// File: rtl/sclk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV enabled cycles and flags
// the cycle on which each rising/falling toggle lands.
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);
  logic [7:0] div;
  logic       term;

  assign term      = en && (div == 8'(CLK_DIV - 1));
  assign rise_tick = term & ~sclk;
  assign fall_tick = term & sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      if (term) begin
        div  <= '0;
        sclk <= ~sclk;
      end else begin
        div <= div + 8'd1;
      end
    end
  end
endmodule

// File: rtl/status_piso.sv
// Status return transmitter: captures status_in one cycle after each sipo_done
// rise and shifts it MSB-first on cs_n/sclk/sdo (mode 0, data changes on fall).
// sipo_done is a level, not a valid/ready pair: only a low-to-high transition
// seen while armed requests a frame; there is no backpressure toward the SIPO.
module status_piso
  import vehicle_link_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = STATUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sipo_done,
  input  logic [DATA_W-1:0] status_in,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdo,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [1:0]        dbg_state
);
  state_e            state;
  logic              sd_q, sd_qq, armed, cap;
  logic [DATA_W-1:0] shreg;
  logic [4:0]        bit_cnt;
  logic [7:0]        gap_cnt;
  logic              gen_en, gen_rst, fall_tick, rise_unused;

  // armed blocks a fake rise when sipo_done is already high as reset releases:
  // a frame needs sipo_done to have been seen low since reset.
  assign cap       = sd_q & ~sd_qq & armed;
  assign gen_en    = (state == ST_SHIFT);
  assign gen_rst   = rst | ~gen_en;
  assign sdo       = shreg[DATA_W-1];
  assign dbg_state = state;

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (gen_rst),
    .en        (gen_en),
    .sclk      (sclk),
    .rise_tick (rise_unused),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_q  <= 1'b0;
      sd_qq <= 1'b0;
      armed <= 1'b0;
    end else begin
      sd_q  <= sipo_done;
      sd_qq <= sd_q;
      if (!sipo_done) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cap && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cap) begin
            shreg   <= status_in;
            bit_cnt <= '0;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (fall_tick) begin
            if (bit_cnt == 5'(DATA_W - 1)) begin
              cs_n    <= 1'b1;
              shreg   <= '0;
              done    <= 1'b1;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_GAP: begin
          // Minimum deselect time before the next capture can start a frame.
          if (gap_cnt == 8'(CLK_DIV - 1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
